serial_subtractor: RTL and testbench

Bit-serial two's-complement subtractor computing DIFF = A - B one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. It is the subtract-direction counterpart to the team's ripple/carry-select adder cells: it uses minimal area and takes multiple cycles. Operands arrive on a valid/ready input handshake. The result leaves on a valid/ready output handshake with unsigned-borrow and signed-overflow flags. It sits in the arithmetic datapath wherever area matters more than latency.

---
 rtl/serial_subtractor_pkg.sv | 13 +
 rtl/serial_subtractor_cell.sv | 15 +
 rtl/serial_subtractor.sv | 132 +++++++++++++
 tb/tb_serial_subtractor.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and legal width bounds.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } sub_state_e;

  localparam int unsigned WidthMin = 2;
  localparam int unsigned WidthMax = 64;

endpackage

// File: rtl/serial_subtractor_cell.sv
// Combinational full-subtractor: one difference bit and the borrow into the next bit.
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one bit per clock through a single full-subtractor cell.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  if (WIDTH < WidthMin || WIDTH > WidthMax) begin : gen_width_check
    $error("serial_subtractor: WIDTH out of range");
  end

  sub_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] diff_sh_q, diff_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             borrow_q, borrow_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             borrow_out_q, borrow_out_d;
  logic             overflow_q, overflow_d;

  logic cell_d;
  logic cell_bout;

  full_subtractor_cell u_cell (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (borrow_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  always_comb begin
    state_d      = state_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    diff_sh_d    = diff_sh_q;
    diff_d       = diff_q;
    count_d      = count_q;
    borrow_d     = borrow_q;
    a_msb_d      = a_msb_q;
    b_msb_d      = b_msb_q;
    borrow_out_d = borrow_out_q;
    overflow_d   = overflow_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_sh_d   = a;
          b_sh_d   = b;
          borrow_d = 1'b0;
          count_d  = '0;
          a_msb_d  = a[WIDTH-1];
          b_msb_d  = b[WIDTH-1];
          state_d  = StRun;
        end
      end
      StRun: begin
        diff_sh_d = {cell_d, diff_sh_q[WIDTH-1:1]};
        a_sh_d    = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d    = {1'b0, b_sh_q[WIDTH-1:1]};
        borrow_d  = cell_bout;
        count_d   = count_q + 1'b1;
        if (count_q == LastBit) begin
          // Result registers only change here so they hold between operations.
          diff_d       = diff_sh_d;
          borrow_out_d = cell_bout;
          overflow_d   = (a_msb_q ^ b_msb_q) & (cell_d ^ a_msb_q);
          state_d      = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      diff_sh_q    <= '0;
      diff_q       <= '0;
      count_q      <= '0;
      borrow_q     <= 1'b0;
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
      borrow_out_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      diff_sh_q    <= diff_sh_d;
      diff_q       <= diff_d;
      count_q      <= count_d;
      borrow_q     <= borrow_d;
      a_msb_q      <= a_msb_d;
      b_msb_q      <= b_msb_d;
      borrow_out_q <= borrow_out_d;
      overflow_q   <= overflow_d;
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StDone);
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH=8, plus a short random stall sweep.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         overflow;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  serial_subtractor #(
    .WIDTH (W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out),
    .overflow   (overflow)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    check_eq("in_ready before accept", in_ready, 1);
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Counts clock edges after the accept edge until out_valid rises (bounded).
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 4 * W) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input int stall);
    logic [W:0]   full;
    logic [W-1:0] exp_d;
    logic         exp_bo;
    logic         exp_ov;
    int           lat;
    full   = {1'b0, va} - {1'b0, vb};
    exp_d  = full[W-1:0];
    exp_bo = (va < vb);
    exp_ov = (va[W-1] != vb[W-1]) && (exp_d[W-1] != va[W-1]);
    out_ready = (stall == 0);
    send(va, vb);
    wait_valid(lat);
    check_eq("latency", lat, W);
    check_eq("diff", diff, exp_d);
    check_eq("borrow_out", borrow_out, exp_bo);
    check_eq("overflow", overflow, exp_ov);
    repeat (stall) tick();
    if (stall > 0) begin
      check_eq("out_valid held under stall", out_valid, 1);
      check_eq("diff held under stall", diff, exp_d);
    end
    out_ready = 1'b1;
    tick();
    check_eq("out_valid after drain", out_valid, 0);
    check_eq("in_ready after drain", in_ready, 1);
    check_eq("diff holds after drain", diff, exp_d);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    #1;
    check_eq("reset in_ready", in_ready, 1);
    check_eq("reset out_valid", out_valid, 0);
    check_eq("reset diff", diff, 0);
    check_eq("reset borrow_out", borrow_out, 0);
    check_eq("reset overflow", overflow, 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Directed vectors from hand-worked arithmetic.
    run_op(8'h35, 8'h12, 0);  // 0x23, 0, 0
    run_op(8'h12, 8'h35, 0);  // 0xDD, 1, 0
    run_op(8'h80, 8'h01, 0);  // 0x7F, 0, 1
    run_op(8'h7F, 8'hFF, 0);  // 0x80, 1, 1
    run_op(8'h00, 8'h00, 0);
    run_op(8'h5C, 8'h5C, 0);
    run_op(8'hA7, 8'h00, 0);
    run_op(8'h01, 8'h80, 2);  // 0x81, 1, 1

    // Backpressure with in_valid pulses during RUN and DONE.
    out_ready = 1'b0;
    send(8'h5A, 8'h3C);
    a        = 8'hFF;
    b        = 8'h01;
    in_valid = 1'b1;
    tick();
    check_eq("in_ready low in RUN", in_ready, 0);
    tick();
    check_eq("in_ready low in RUN 2", in_ready, 0);
    in_valid = 1'b0;
    wait_valid(lat);
    check_eq("latency with pulses", lat + 2, W);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      check_eq("bp out_valid", out_valid, 1);
      check_eq("bp diff", diff, 8'h1E);
      check_eq("bp borrow_out", borrow_out, 0);
      check_eq("bp in_ready", in_ready, 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_eq("bp diff before drain", diff, 8'h1E);
    tick();
    check_eq("bp in_ready after drain", in_ready, 1);
    check_eq("bp out_valid after drain", out_valid, 0);
    repeat (W + 2) tick();
    check_eq("no spurious result", out_valid, 0);

    // Reset in the middle of RUN aborts the operation.
    send(8'h55, 8'h11);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check_eq("mid-run reset in_ready", in_ready, 1);
    check_eq("mid-run reset out_valid", out_valid, 0);
    check_eq("mid-run reset diff", diff, 0);
    check_eq("mid-run reset borrow_out", borrow_out, 0);
    check_eq("mid-run reset overflow", overflow, 0);
    tick();
    rst = 1'b0;
    repeat (W + 2) tick();
    check_eq("no result after reset", out_valid, 0);
    run_op(8'h0A, 8'h03, 0);  // 0x07

    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      run_op(W'($urandom), W'($urandom), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
